hazard_issue_ctrl: RTL and testbench
====================================

// Module: hazard_issue_ctrl
// PURPOSE
//  Issue controller for the Decode->Execute boundary. A per-register pending-write scoreboard
//  generates the dependence stall (I_DepStall of Execute). A branch FSM holds fetch (I_FetchStall)
//  from branch/JSR issue until Execute's target resolves, then drains. Sequences what Execute may consume.
// PARAMETERS
//  NUM_REGS     16  architectural registers tracked
//  IDX_W        4   register index width
//  CNT_W        2   pending-write counter width per register (max 2^CNT_W-1 in flight)
//  DRAIN_CYC    2   fetch-stall cycles held after branch resolve (1..7)
// PORTS
//  I_CLOCK          in   1          clock; all state updates on negedge I_CLOCK
//  I_RESET          in   1          synchronous reset, active-high
//  I_LOCK           in   1          pipeline enable; 0 freezes all state
//  I_DecValid       in   1          decode holds a valid instruction
//  I_DecSrc1Idx     in   IDX_W      source 1 register
//  I_DecSrc2Idx     in   IDX_W      source 2 register
//  I_DecUsesSrc1    in   1          instruction reads source 1
//  I_DecUsesSrc2    in   1          instruction reads source 2
//  I_DecDestIdx     in   IDX_W      destination register
//  I_DecWritesDest  in   1          instruction writes destination
//  I_DecIsBranch    in   1          BRx or JSR
//  I_WBValid        in   1          writeback retiring a register write
//  I_WBDestIdx      in   IDX_W      writeback register
//  I_BrResolve      in   1          Execute target valid (one-cycle pulse)
//  I_BrTaken        in   1          qualifies I_BrResolve
//  O_Issue          out  1          instruction accepted this cycle (comb)
//  O_DepStall       out  1          data hazard stall (comb)
//  O_FetchStall     out  1          fetch hold (registered, from FSM state)
//  O_Redirect       out  1          one-cycle pulse: taken branch resolved (registered)
//  O_BusyMask       out  NUM_REGS   bit r = pending[r]!=0 (registered)
//  O_Underflow      out  1          sticky: writeback to register with pending 0
// BEHAVIOUR
//  Reset: all pending counters 0, FSM=IDLE, drain count 0; O_FetchStall=0, O_Redirect=0,
//   O_BusyMask=0, O_Underflow=0; O_Issue and O_DepStall forced 0 while I_RESET=1.
//  Hazard: haz = (UsesSrc1 & pending[Src1]!=0) | (UsesSrc2 & pending[Src2]!=0)
//   | (WritesDest & pending[Dest]==max). No bypass: a same-cycle WB to a source still stalls;
//   issue happens next cycle.
//  O_DepStall = I_LOCK & I_DecValid & haz & state==IDLE.
//  O_Issue    = I_LOCK & I_DecValid & ~haz & state==IDLE.
//  Counters (I_LOCK=1): +1 on issue with WritesDest; -1 on I_WBValid; both same index -> unchanged.
//   WB with pending 0 -> counter stays 0, O_Underflow set until reset. Never wraps.
//  FSM: IDLE --issue & IsBranch--> BR_WAIT; BR_WAIT --I_BrResolve--> DRAIN (load DRAIN_CYC);
//   DRAIN decrements, ->IDLE after count reaches 1. O_FetchStall=1 in BR_WAIT and DRAIN.
//   O_Redirect=1 the cycle after I_BrResolve & I_BrTaken. I_BrResolve outside BR_WAIT is ignored.
//  A branch that also writes (JSR) updates the scoreboard on issue as normal.
//  I_LOCK=0: counters, FSM, drain count held; registered outputs hold; O_Redirect cleared.
//  Reset mid-branch or with writes pending: everything returns to reset values next edge;
//   later WBs for pre-reset writes set O_Underflow (the environment flushes).
// TESTING
//  1 Issue ADD r3 (writes), next instr reads r3 -> O_DepStall=1, BusyMask[3]=1; WB r3 -> issue next cycle.
//  2 Three issues writing r5 (CNT_W=2) -> 4th writer to r5 stalls; one WB -> 4th issues.
//  3 Same-cycle issue-writes r2 and WB r2 with pending[2]=1 -> pending[2] stays 1.
//  4 BRZ issue -> FetchStall=1; Resolve taken at cycle 3 -> Redirect pulse, FetchStall low after 2 cycles.
//  5 WB r7 with pending 0 -> O_Underflow=1, stays 1 until I_RESET.
//  6 Reset asserted in BR_WAIT with pending[1]=2 -> next edge: FetchStall=0, BusyMask=0, IDLE.

Source files
------------

// File: rtl/hazard_issue_ctrl.sv
// Decode->Execute issue controller: per-register pending-write scoreboard for
// data hazards, plus a branch FSM that holds fetch until the target resolves
// and for a short drain afterwards. All state changes on the falling clock edge.
module hazard_issue_ctrl #(
    parameter int unsigned NUM_REGS  = 16,
    parameter int unsigned IDX_W     = 4,
    parameter int unsigned CNT_W     = 2,
    parameter int unsigned DRAIN_CYC = 2
) (
    input  logic                I_CLOCK,
    input  logic                I_RESET,
    input  logic                I_LOCK,
    input  logic                I_DecValid,
    input  logic [IDX_W-1:0]    I_DecSrc1Idx,
    input  logic [IDX_W-1:0]    I_DecSrc2Idx,
    input  logic                I_DecUsesSrc1,
    input  logic                I_DecUsesSrc2,
    input  logic [IDX_W-1:0]    I_DecDestIdx,
    input  logic                I_DecWritesDest,
    input  logic                I_DecIsBranch,
    input  logic                I_WBValid,
    input  logic [IDX_W-1:0]    I_WBDestIdx,
    input  logic                I_BrResolve,
    input  logic                I_BrTaken,
    output logic                O_Issue,
    output logic                O_DepStall,
    output logic                O_FetchStall,
    output logic                O_Redirect,
    output logic [NUM_REGS-1:0] O_BusyMask,
    output logic                O_Underflow
);

    localparam logic [CNT_W-1:0] CntMax    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);
    localparam logic [2:0]       DrainLoad = 3'(DRAIN_CYC);

    typedef enum logic [1:0] {StIdle, StBrWait, StDrain} state_e;

    state_e           state_q, state_d;
    logic [2:0]       drain_q, drain_d;
    logic             redirect_q, redirect_d;
    logic             underflow_q, underflow_d;
    logic [CNT_W-1:0] pending_q [NUM_REGS];
    logic [CNT_W-1:0] pending_d [NUM_REGS];

    logic                haz;
    logic                idle;
    logic                issue;
    logic [NUM_REGS-1:0] inc_vec;
    logic [NUM_REGS-1:0] dec_vec;

    // Hazard detect and issue decision; no writeback bypass, so a same-cycle
    // retire to a source still stalls.
    always_comb begin
        haz = (I_DecUsesSrc1 && (pending_q[I_DecSrc1Idx] != '0))
            || (I_DecUsesSrc2 && (pending_q[I_DecSrc2Idx] != '0))
            || (I_DecWritesDest && (pending_q[I_DecDestIdx] == CntMax));
        idle       = (state_q == StIdle);
        issue      = !I_RESET && I_LOCK && I_DecValid && !haz && idle;
        O_Issue    = issue;
        O_DepStall = !I_RESET && I_LOCK && I_DecValid && haz && idle;
    end

    // Per-register increment (issued writer) and decrement (writeback) strobes.
    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            inc_vec[r] = issue && I_DecWritesDest && (I_DecDestIdx == IDX_W'(r));
            dec_vec[r] = I_WBValid && (I_WBDestIdx == IDX_W'(r));
        end
    end

    // Scoreboard next state; a writeback to an idle counter saturates at 0
    // and raises the sticky underflow flag instead of wrapping.
    always_comb begin
        underflow_d = underflow_q;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            pending_d[r] = pending_q[r];
            if (inc_vec[r] && !dec_vec[r]) begin
                pending_d[r] = pending_q[r] + CntOne;
            end else if (dec_vec[r] && !inc_vec[r]) begin
                if (pending_q[r] == '0) begin
                    underflow_d = 1'b1;
                end else begin
                    pending_d[r] = pending_q[r] - CntOne;
                end
            end
        end
    end

    // Branch FSM next state: wait for resolve, then hold fetch for the drain.
    always_comb begin
        state_d    = state_q;
        drain_d    = drain_q;
        redirect_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (issue && I_DecIsBranch) begin
                    state_d = StBrWait;
                end
            end
            StBrWait: begin
                if (I_BrResolve) begin
                    state_d    = StDrain;
                    drain_d    = DrainLoad;
                    redirect_d = I_BrTaken;
                end
            end
            StDrain: begin
                if (drain_q <= 3'd1) begin
                    state_d = StIdle;
                    drain_d = '0;
                end else begin
                    drain_d = drain_q - 3'd1;
                end
            end
            default: begin
                state_d = StIdle;
                drain_d = '0;
            end
        endcase
    end

    // State registers; reset wins over I_LOCK, and a frozen pipe drops the redirect pulse.
    always_ff @(negedge I_CLOCK) begin
        if (I_RESET) begin
            state_q     <= StIdle;
            drain_q     <= '0;
            redirect_q  <= 1'b0;
            underflow_q <= 1'b0;
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                pending_q[r] <= '0;
            end
        end else if (I_LOCK) begin
            state_q     <= state_d;
            drain_q     <= drain_d;
            redirect_q  <= redirect_d;
            underflow_q <= underflow_d;
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                pending_q[r] <= pending_d[r];
            end
        end else begin
            redirect_q <= 1'b0;
        end
    end

    // Outputs taken straight from registered state.
    always_comb begin
        O_FetchStall = (state_q != StIdle);
        O_Redirect   = redirect_q;
        O_Underflow  = underflow_q;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            O_BusyMask[r] = (pending_q[r] != '0);
        end
    end

endmodule

// File: tb/tb_hazard_issue_ctrl.sv
// Bench for hazard_issue_ctrl: directed vector table for the scoreboard and
// branch corner cases, then random traffic against a behavioural model.
module tb_hazard_issue_ctrl;

    localparam int NR    = 16;
    localparam int MAXC  = 3;
    localparam int DRAIN = 2;

    logic        clk = 1'b0;
    logic        rst, lock, valid, u1, u2, wd, br, wb, res, tk;
    logic [3:0]  s1, s2, d, wbi;
    logic        o_issue, o_dep, o_fs, o_red, o_uf;
    logic [15:0] o_busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_issue_ctrl #(
        .NUM_REGS (16),
        .IDX_W    (4),
        .CNT_W    (2),
        .DRAIN_CYC(2)
    ) dut (
        .I_CLOCK        (clk),
        .I_RESET        (rst),
        .I_LOCK         (lock),
        .I_DecValid     (valid),
        .I_DecSrc1Idx   (s1),
        .I_DecSrc2Idx   (s2),
        .I_DecUsesSrc1  (u1),
        .I_DecUsesSrc2  (u2),
        .I_DecDestIdx   (d),
        .I_DecWritesDest(wd),
        .I_DecIsBranch  (br),
        .I_WBValid      (wb),
        .I_WBDestIdx    (wbi),
        .I_BrResolve    (res),
        .I_BrTaken      (tk),
        .O_Issue        (o_issue),
        .O_DepStall     (o_dep),
        .O_FetchStall   (o_fs),
        .O_Redirect     (o_red),
        .O_BusyMask     (o_busy),
        .O_Underflow    (o_uf)
    );

    typedef struct {
        logic rst, lock, valid, u1, u2, wd, br, wb, res, tk;
        logic [3:0] s1, s2, d, wbi;
        logic e_issue, e_dep, e_fs, e_red, e_uf;
        logic [15:0] e_busy;
    } vec_t;

    vec_t tbl[52];

    function automatic vec_t v(input int rst_a, lock_a, valid_a, s1_a, u1_a, s2_a, u2_a,
                               d_a, wd_a, br_a, wb_a, wbi_a, res_a, tk_a,
                               ei, ed, efs, ered, ebusy, euf);
        vec_t t;
        t.rst = 1'(rst_a);  t.lock = 1'(lock_a); t.valid = 1'(valid_a);
        t.s1 = 4'(s1_a);    t.u1 = 1'(u1_a);     t.s2 = 4'(s2_a);  t.u2 = 1'(u2_a);
        t.d = 4'(d_a);      t.wd = 1'(wd_a);     t.br = 1'(br_a);
        t.wb = 1'(wb_a);    t.wbi = 4'(wbi_a);   t.res = 1'(res_a); t.tk = 1'(tk_a);
        t.e_issue = 1'(ei); t.e_dep = 1'(ed);    t.e_fs = 1'(efs); t.e_red = 1'(ered);
        t.e_busy = 16'(ebusy); t.e_uf = 1'(euf);
        return t;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        rst = t.rst; lock = t.lock; valid = t.valid;
        s1 = t.s1; u1 = t.u1; s2 = t.s2; u2 = t.u2; d = t.d; wd = t.wd; br = t.br;
        wb = t.wb; wbi = t.wbi; res = t.res; tk = t.tk;
    endtask

    task automatic raw_reset();
        drive(v(1,1,0, 0,0,0,0, 0,0,0, 0,0,0,0, 0,0,0,0,0,0));
        repeat (2) @(negedge clk);
        #1;
    endtask

    // Behavioural model: counts per register and a simple "waiting / drain left" view.
    int pend[NR];
    bit m_wait, m_red, m_uf;
    int m_drain;

    function automatic bit m_haz();
        return (u1 && pend[s1] != 0) || (u2 && pend[s2] != 0) || (wd && pend[d] == MAXC);
    endfunction

    function automatic bit m_idle();
        return !m_wait && m_drain == 0;
    endfunction

    function automatic bit m_issue();
        return !rst && lock && valid && !m_haz() && m_idle();
    endfunction

    task automatic m_reset();
        foreach (pend[i]) pend[i] = 0;
        m_wait = 0; m_red = 0; m_uf = 0; m_drain = 0;
    endtask

    task automatic m_step();
        int tmp[NR];
        bit iss;
        iss = m_issue();
        if (rst) begin
            m_reset();
        end else if (lock) begin
            tmp = pend;
            if (iss && wd) tmp[d] = tmp[d] + 1;
            if (wb) begin
                if (tmp[wbi] == 0) m_uf = 1;
                else tmp[wbi] = tmp[wbi] - 1;
            end
            pend = tmp;
            m_red = 0;
            if (m_wait) begin
                if (res) begin
                    m_wait = 0;
                    m_drain = DRAIN;
                    m_red = tk;
                end
            end else if (m_drain > 0) begin
                m_drain--;
            end else if (iss && br) begin
                m_wait = 1;
            end
        end else begin
            m_red = 0;
        end
    endtask

    function automatic logic [15:0] m_busy();
        logic [15:0] b = '0;
        for (int i = 0; i < NR; i++) b[i] = (pend[i] != 0);
        return b;
    endfunction

    initial begin
        //           rst lk vl s1 u1 s2 u2 d wd br wb wbi rs tk | iss dep fs red busy uf
        tbl[0]  = v(1,1,1, 1,1,2,1, 3,1,0, 0,0,0,0, 0,0,0,0,'h0000,0);
        tbl[1]  = v(0,1,1, 1,1,2,1, 3,1,0, 0,0,0,0, 1,0,0,0,'h0000,0);
        tbl[2]  = v(0,1,1, 3,1,0,0, 4,1,0, 0,0,0,0, 0,1,0,0,'h0008,0);
        tbl[3]  = v(0,1,1, 3,1,0,0, 4,1,0, 1,3,0,0, 0,1,0,0,'h0008,0);
        tbl[4]  = v(0,1,1, 3,1,0,0, 4,1,0, 0,0,0,0, 1,0,0,0,'h0000,0);
        tbl[5]  = v(0,1,0, 0,0,0,0, 0,0,0, 1,4,0,0, 0,0,0,0,'h0010,0);
        tbl[6]  = v(0,1,1, 0,0,0,0, 5,1,0, 0,0,0,0, 1,0,0,0,'h0000,0);
        tbl[7]  = v(0,1,1, 0,0,0,0, 5,1,0, 0,0,0,0, 1,0,0,0,'h0020,0);
        tbl[8]  = v(0,1,1, 0,0,0,0, 5,1,0, 0,0,0,0, 1,0,0,0,'h0020,0);
        tbl[9]  = v(0,1,1, 0,0,0,0, 5,1,0, 0,0,0,0, 0,1,0,0,'h0020,0);
        tbl[10] = v(0,1,1, 0,0,0,0, 5,1,0, 1,5,0,0, 0,1,0,0,'h0020,0);
        tbl[11] = v(0,1,1, 0,0,0,0, 5,1,0, 0,0,0,0, 1,0,0,0,'h0020,0);
        tbl[12] = v(0,1,0, 0,0,0,0, 0,0,0, 1,5,0,0, 0,0,0,0,'h0020,0);
        tbl[13] = v(0,1,0, 0,0,0,0, 0,0,0, 1,5,0,0, 0,0,0,0,'h0020,0);
        tbl[14] = v(0,1,0, 0,0,0,0, 0,0,0, 1,5,0,0, 0,0,0,0,'h0020,0);
        tbl[15] = v(0,1,1, 0,0,0,0, 2,1,0, 0,0,0,0, 1,0,0,0,'h0000,0);
        tbl[16] = v(0,1,1, 0,0,0,0, 2,1,0, 1,2,0,0, 1,0,0,0,'h0004,0);
        tbl[17] = v(0,1,0, 0,0,0,0, 0,0,0, 0,0,0,0, 0,0,0,0,'h0004,0);
        tbl[18] = v(0,1,0, 0,0,0,0, 0,0,0, 1,2,0,0, 0,0,0,0,'h0004,0);
        tbl[19] = v(0,1,0, 0,0,0,0, 0,0,0, 0,0,0,0, 0,0,0,0,'h0000,0);
        tbl[20] = v(0,1,1, 1,1,0,0, 0,0,1, 0,0,0,0, 1,0,0,0,'h0000,0);
        tbl[21] = v(0,1,1, 1,1,0,0, 0,0,0, 0,0,0,0, 0,0,1,0,'h0000,0);
        tbl[22] = v(0,1,0, 0,0,0,0, 0,0,0, 0,0,0,0, 0,0,1,0,'h0000,0);
        tbl[23] = v(0,1,0, 0,0,0,0, 0,0,0, 0,0,1,1, 0,0,1,0,'h0000,0);
        tbl[24] = v(0,1,0, 0,0,0,0, 0,0,0, 0,0,0,0, 0,0,1,1,'h0000,0);
        tbl[25] = v(0,1,0, 0,0,0,0, 0,0,0, 0,0,0,0, 0,0,1,0,'h0000,0);
        tbl[26] = v(0,1,1, 1,1,0,0, 0,0,0, 0,0,0,0, 1,0,0,0,'h0000,0);
        tbl[27] = v(0,1,0, 0,0,0,0, 0,0,0, 0,0,1,1, 0,0,0,0,'h0000,0);
        tbl[28] = v(0,1,0, 0,0,0,0, 0,0,0, 0,0,0,0, 0,0,0,0,'h0000,0);
        tbl[29] = v(0,1,1, 0,0,0,0, 0,0,1, 0,0,0,0, 1,0,0,0,'h0000,0);
        tbl[30] = v(0,1,0, 0,0,0,0, 0,0,0, 0,0,1,0, 0,0,1,0,'h0000,0);
        tbl[31] = v(0,1,0, 0,0,0,0, 0,0,0, 0,0,0,0, 0,0,1,0,'h0000,0);
        tbl[32] = v(0,1,0, 0,0,0,0, 0,0,0, 0,0,0,0, 0,0,1,0,'h0000,0);
        tbl[33] = v(0,1,0, 0,0,0,0, 0,0,0, 0,0,0,0, 0,0,0,0,'h0000,0);
        tbl[34] = v(0,1,1, 0,0,0,0, 0,0,1, 0,0,0,0, 1,0,0,0,'h0000,0);
        tbl[35] = v(0,0,0, 0,0,0,0, 0,0,0, 0,0,1,1, 0,0,1,0,'h0000,0);
        tbl[36] = v(0,1,0, 0,0,0,0, 0,0,0, 0,0,0,0, 0,0,1,0,'h0000,0);
        tbl[37] = v(0,1,0, 0,0,0,0, 0,0,0, 0,0,1,1, 0,0,1,0,'h0000,0);
        tbl[38] = v(0,0,0, 0,0,0,0, 0,0,0, 0,0,0,0, 0,0,1,1,'h0000,0);
        tbl[39] = v(0,1,0, 0,0,0,0, 0,0,0, 0,0,0,0, 0,0,1,0,'h0000,0);
        tbl[40] = v(0,1,0, 0,0,0,0, 0,0,0, 0,0,0,0, 0,0,1,0,'h0000,0);
        tbl[41] = v(0,1,0, 0,0,0,0, 0,0,0, 0,0,0,0, 0,0,0,0,'h0000,0);
        tbl[42] = v(0,1,0, 0,0,0,0, 0,0,0, 1,7,0,0, 0,0,0,0,'h0000,0);
        tbl[43] = v(0,1,0, 0,0,0,0, 0,0,0, 0,0,0,0, 0,0,0,0,'h0000,1);
        tbl[44] = v(0,1,0, 0,0,0,0, 0,0,0, 0,0,0,0, 0,0,0,0,'h0000,1);
        tbl[45] = v(0,1,1, 0,0,0,0, 1,1,0, 0,0,0,0, 1,0,0,0,'h0000,1);
        tbl[46] = v(0,1,1, 0,0,0,0, 1,1,0, 0,0,0,0, 1,0,0,0,'h0002,1);
        tbl[47] = v(0,1,1, 0,0,0,0, 0,0,1, 0,0,0,0, 1,0,0,0,'h0002,1);
        tbl[48] = v(1,1,1, 0,0,0,0, 1,1,0, 0,0,0,0, 0,0,1,0,'h0002,1);
        tbl[49] = v(0,1,0, 0,0,0,0, 0,0,0, 0,0,0,0, 0,0,0,0,'h0000,0);
        tbl[50] = v(0,1,0, 0,0,0,0, 0,0,0, 1,1,0,0, 0,0,0,0,'h0000,0);
        tbl[51] = v(0,1,0, 0,0,0,0, 0,0,0, 0,0,0,0, 0,0,0,0,'h0000,1);

        raw_reset();

        // Directed vectors: drive after the falling edge, compare mid-cycle.
        for (int i = 0; i < 52; i++) begin
            drive(tbl[i]);
            @(posedge clk);
            check($sformatf("vec%0d issue", i), 16'(o_issue), 16'(tbl[i].e_issue));
            check($sformatf("vec%0d depstall", i), 16'(o_dep), 16'(tbl[i].e_dep));
            check($sformatf("vec%0d fetchstall", i), 16'(o_fs), 16'(tbl[i].e_fs));
            check($sformatf("vec%0d redirect", i), 16'(o_red), 16'(tbl[i].e_red));
            check($sformatf("vec%0d busymask", i), o_busy, tbl[i].e_busy);
            check($sformatf("vec%0d underflow", i), 16'(o_uf), 16'(tbl[i].e_uf));
            @(negedge clk);
            #1;
        end

        // Random traffic on a few registers so hazards and saturation are frequent.
        raw_reset();
        m_reset();
        for (int c = 0; c < 600; c++) begin
            rst   = ($urandom_range(0, 59) == 0);
            lock  = ($urandom_range(0, 7) != 0);
            valid = ($urandom_range(0, 3) != 0);
            s1    = 4'($urandom_range(0, 3));
            s2    = 4'($urandom_range(0, 3));
            d     = 4'($urandom_range(0, 3));
            u1    = 1'($urandom_range(0, 1));
            u2    = 1'($urandom_range(0, 1));
            wd    = ($urandom_range(0, 2) != 0);
            br    = ($urandom_range(0, 7) == 0);
            wb    = ($urandom_range(0, 2) == 0);
            wbi   = 4'($urandom_range(0, 3));
            res   = ($urandom_range(0, 3) == 0);
            tk    = 1'($urandom_range(0, 1));
            @(posedge clk);
            check($sformatf("rnd%0d issue", c), 16'(o_issue), 16'(m_issue()));
            check($sformatf("rnd%0d depstall", c), 16'(o_dep),
                  16'(!rst && lock && valid && m_haz() && m_idle()));
            check($sformatf("rnd%0d fetchstall", c), 16'(o_fs), 16'(!m_idle()));
            check($sformatf("rnd%0d redirect", c), 16'(o_red), 16'(m_red));
            check($sformatf("rnd%0d busymask", c), o_busy, m_busy());
            check($sformatf("rnd%0d underflow", c), 16'(o_uf), 16'(m_uf));
            @(negedge clk);
            m_step();
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
